// File: rtl/gamepad_report_encoder.sv
// Gamepad front end: synchronise and debounce the button pins, encode a signed X/Y
// delta plus action bits, and emit the report in parallel or as a parity-framed serial stream.
module gamepad_report_encoder #(
  parameter int COORD_W    = 8,
  parameter int NUM_OP     = 4,
  parameter int STEP       = 1,
  parameter int DEB_CYCLES = 4,
  parameter int BAUD_DIV   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mode,
  input  logic [3:0]         dir_in,
  input  logic [NUM_OP-1:0]  op_in,
  output logic [COORD_W-1:0] coord_p,
  output logic [NUM_OP-1:0]  op_p,
  output logic               par_valid,
  output logic               conflict,
  output logic               ser_out,
  output logic               ser_busy
);

  localparam int VEC_W  = NUM_OP + 4;
  localparam int HALF   = COORD_W / 2;
  localparam int PAY_W  = COORD_W + NUM_OP;
  localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
  localparam int BAUD_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int BIT_W  = $clog2(PAY_W);
  localparam logic [HALF-1:0] STEP_V = HALF'(STEP);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } tx_state_e;

  logic [VEC_W-1:0] sync1, sync2, sync_prev, deb;
  logic [DEB_W-1:0] deb_cnt;
  logic             deb_loaded;
  logic             rpt_evt;

  // NOTE: every clocked block uses non-blocking assignments so all registers
  // sample pre-edge values; a blocking assignment here would collapse the sync chain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1      <= '0;
      sync2      <= '0;
      sync_prev  <= '0;
      deb        <= '0;
      deb_cnt    <= '0;
      deb_loaded <= 1'b0;
    end else begin
      sync1      <= {op_in, dir_in};
      sync2      <= sync1;
      sync_prev  <= sync2;
      deb_loaded <= 1'b0;
      if (sync2 != sync_prev) begin
        deb_cnt <= '0;
      end else if (sync2 != deb) begin
        if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
          deb        <= sync2;
          deb_cnt    <= '0;
          deb_loaded <= 1'b1;
        end else begin
          deb_cnt <= deb_cnt + DEB_W'(1);
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  // Opposing directions cancel; dir bits are {D,U,R,L}.
  logic [HALF-1:0] x_d, y_d;
  logic            conflict_d;

  // NOTE: each always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    x_d        = '0;
    y_d        = '0;
    conflict_d = (deb[0] & deb[1]) | (deb[2] & deb[3]);
    if (deb[1] && !deb[0]) x_d = STEP_V;
    else if (deb[0] && !deb[1]) x_d = -STEP_V;
    if (deb[2] && !deb[3]) y_d = STEP_V;
    else if (deb[3] && !deb[2]) y_d = -STEP_V;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      coord_p   <= '0;
      op_p      <= '0;
      par_valid <= 1'b0;
      conflict  <= 1'b0;
      rpt_evt   <= 1'b0;
    end else begin
      par_valid <= deb_loaded & ~mode;
      rpt_evt   <= deb_loaded;
      conflict  <= conflict_d;
      if (deb_loaded) begin
        coord_p <= {x_d, y_d};
        op_p    <= deb[VEC_W-1:4];
      end
    end
  end

  tx_state_e         state;
  logic [PAY_W-1:0]  shreg;
  logic              par_bit;
  logic              pending;
  logic [BAUD_W-1:0] baud_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic              start_req;

  // coord_p/op_p always hold the newest report, so they double as the pending snapshot.
  assign start_req = mode & (pending | rpt_evt);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      shreg    <= '0;
      par_bit  <= 1'b0;
      pending  <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      ser_out  <= 1'b1;
      ser_busy <= 1'b0;
    end else if (state == S_IDLE) begin
      pending <= 1'b0;
      if (mode && rpt_evt) begin
        shreg    <= {op_p, coord_p};
        par_bit  <= ^{op_p, coord_p};
        baud_cnt <= '0;
        ser_out  <= 1'b0;
        ser_busy <= 1'b1;
        state    <= S_START;
      end
    end else begin
      pending <= mode & (pending | rpt_evt);
      if (baud_cnt != BAUD_W'(BAUD_DIV - 1)) begin
        baud_cnt <= baud_cnt + BAUD_W'(1);
      end else begin
        baud_cnt <= '0;
        case (state)
          S_START: begin
            ser_out <= shreg[0];
            shreg   <= shreg >> 1;
            bit_cnt <= '0;
            state   <= S_DATA;
          end
          S_DATA: begin
            if (bit_cnt == BIT_W'(PAY_W - 1)) begin
              ser_out <= par_bit;
              state   <= S_PARITY;
            end else begin
              ser_out <= shreg[0];
              shreg   <= shreg >> 1;
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end
          S_PARITY: begin
            ser_out <= 1'b1;
            state   <= S_STOP;
          end
          S_STOP: begin
            pending <= 1'b0;
            if (start_req) begin
              shreg   <= {op_p, coord_p};
              par_bit <= ^{op_p, coord_p};
              ser_out <= 1'b0;
              state   <= S_START;
            end else begin
              ser_out  <= 1'b1;
              ser_busy <= 1'b0;
              state    <= S_IDLE;
            end
          end
          default: begin
            ser_out  <= 1'b1;
            ser_busy <= 1'b0;
            state    <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gamepad_report_encoder.sv
// Randomised scoreboard bench for gamepad_report_encoder: a timing-aware report model
// feeds expected parallel pulses and serial frames; independent monitors compare them.
module tb_gamepad_report_encoder;
  localparam int COORD_W    = 8;
  localparam int NUM_OP     = 4;
  localparam int STEP       = 1;
  localparam int DEB_CYCLES = 4;
  localparam int BAUD_DIV   = 4;
  localparam int HALF       = COORD_W / 2;
  localparam int PAY_W      = COORD_W + NUM_OP;
  localparam int FRAME_W    = PAY_W + 3;
  localparam int FRAME_CYC  = FRAME_W * BAUD_DIV;
  localparam int VEC_W      = NUM_OP + 4;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               mode = 1'b0;
  logic [3:0]         dir_in = '0;
  logic [NUM_OP-1:0]  op_in = '0;
  logic [COORD_W-1:0] coord_p;
  logic [NUM_OP-1:0]  op_p;
  logic               par_valid, conflict, ser_out, ser_busy;

  gamepad_report_encoder #(
    .COORD_W(COORD_W), .NUM_OP(NUM_OP), .STEP(STEP),
    .DEB_CYCLES(DEB_CYCLES), .BAUD_DIV(BAUD_DIV)
  ) dut (
    .clk(clk), .reset(reset), .mode(mode), .dir_in(dir_in), .op_in(op_in),
    .coord_p(coord_p), .op_p(op_p), .par_valid(par_valid), .conflict(conflict),
    .ser_out(ser_out), .ser_busy(ser_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_chk  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct {
    int                 cyc;
    logic [COORD_W-1:0] coord;
    logic [NUM_OP-1:0]  op;
    logic               conf;
  } par_item_t;

  typedef struct {
    int                 cyc;
    logic [FRAME_W-1:0] bits;
  } frm_item_t;

  par_item_t par_q[$];
  frm_item_t frm_q[$];

  // Reference model state: the accepted button vector and the serial link's schedule.
  logic [3:0]         m_dir = '0;
  logic [NUM_OP-1:0]  m_op = '0;
  int                 frame_end = -1000;
  bit                 pend = 1'b0;
  logic [COORD_W-1:0] pend_coord = '0;
  logic [NUM_OP-1:0]  pend_op = '0;
  logic [FRAME_W-1:0] last_rx = '0;

  function automatic logic [COORD_W-1:0] model_coord(input logic [3:0] d);
    int x, y;
    logic [HALF-1:0] xh, yh;
    x  = (d[1] ? STEP : 0) - (d[0] ? STEP : 0);
    y  = (d[2] ? STEP : 0) - (d[3] ? STEP : 0);
    xh = x[HALF-1:0];
    yh = y[HALF-1:0];
    return {xh, yh};
  endfunction

  function automatic logic model_conflict(input logic [3:0] d);
    return (d[0] && d[1]) || (d[2] && d[3]);
  endfunction

  function automatic logic [FRAME_W-1:0] model_frame(input logic [COORD_W-1:0] c,
                                                     input logic [NUM_OP-1:0] o);
    logic [PAY_W-1:0] pay;
    pay = {o, c};
    return {1'b1, ^pay, pay, 1'b0};
  endfunction

  // A frame occupies [start, start+FRAME_CYC); a later event either queues or starts a frame.
  task automatic serial_event(input int s, input logic [COORD_W-1:0] c, input logic [NUM_OP-1:0] o);
    if (pend && frame_end < s) begin
      frm_q.push_back('{frame_end, model_frame(pend_coord, pend_op)});
      frame_end += FRAME_CYC;
      pend = 1'b0;
    end
    if (s <= frame_end) begin
      pend       = 1'b1;
      pend_coord = c;
      pend_op    = o;
    end else begin
      frm_q.push_back('{s, model_frame(c, o)});
      frame_end = s + FRAME_CYC;
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      if (pend && cyc >= frame_end) begin
        frm_q.push_back('{frame_end, model_frame(pend_coord, pend_op)});
        frame_end += FRAME_CYC;
        pend = 1'b0;
      end
    end
  endtask

  task automatic check_state();
    check("coord_p", coord_p, model_coord(m_dir));
    check("op_p", op_p, m_op);
    check("conflict", conflict, model_conflict(m_dir));
  endtask

  // Called at a falling edge; the next rising edge samples the new level into sync stage 1.
  task automatic apply(input logic [3:0] d, input logic [NUM_OP-1:0] o, input int hold);
    int c0;
    logic [COORD_W-1:0] c;
    c0 = cyc + 1;
    dir_in = d;
    op_in  = o;
    if ({o, d} != {m_op, m_dir}) begin
      m_dir = d;
      m_op  = o;
      c     = model_coord(d);
      if (!mode) par_q.push_back('{c0 + DEB_CYCLES + 3, c, o, model_conflict(d)});
      else serial_event(c0 + DEB_CYCLES + 4, c, o);
    end
    wait_cycles(hold);
    check_state();
  endtask

  task automatic glitch(input logic [VEC_W-1:0] mask, input int len);
    {op_in, dir_in} = {m_op, m_dir} ^ mask;
    wait_cycles(len);
    {op_in, dir_in} = {m_op, m_dir};
    wait_cycles(3);
    check_state();
  endtask

  task automatic set_mode(input logic m);
    mode = m;
    if (!m) pend = 1'b0;
    wait_cycles(10);
  endtask

  always @(negedge clk) begin : mon_par
    par_item_t it;
    if (reset && par_valid) begin
      if (par_q.size() == 0) check("par_unexpected", par_q.size(), 1);
      else begin
        it = par_q.pop_front();
        check("par_cycle", cyc, it.cyc);
        check("par_coord", coord_p, it.coord);
        check("par_op", op_p, it.op);
        check("par_conflict", conflict, it.conf);
      end
    end
  end

  int fcyc = 0;
  int fstart = 0;
  logic [FRAME_W-1:0] rx = '0;

  always @(negedge clk) begin : mon_ser
    frm_item_t it;
    if (!reset) begin
      fcyc = 0;
    end else if (ser_busy) begin
      if (fcyc == 0) fstart = cyc;
      if (fcyc % BAUD_DIV == BAUD_DIV / 2) rx[fcyc / BAUD_DIV] = ser_out;
      fcyc++;
      if (fcyc == FRAME_CYC) begin
        fcyc    = 0;
        last_rx = rx;
        if (frm_q.size() == 0) check("frame_unexpected", frm_q.size(), 1);
        else begin
          it = frm_q.pop_front();
          check("frame_start", fstart, it.cyc);
          check("frame_bits", rx, it.bits);
        end
      end
    end else if (fcyc != 0) begin
      check("busy_len", fcyc, FRAME_CYC);
      fcyc = 0;
    end else begin
      check("idle_line", ser_out, 1'b1);
    end
  end

  initial begin
    logic [FRAME_W-1:0] exp_ra;
    exp_ra = {1'b1, 1'b0, 4'b0001, 8'h10, 1'b0};

    repeat (3) @(negedge clk);
    check("rst_coord", coord_p, 0);
    check("rst_op", op_p, 0);
    check("rst_par_valid", par_valid, 0);
    check("rst_conflict", conflict, 0);
    check("rst_ser_out", ser_out, 1);
    check("rst_ser_busy", ser_busy, 0);
    reset = 1'b1;
    wait_cycles(5);

    // Mode 0 directed: L, release, U, D, U+D, A.
    apply(4'b0001, 4'b0000, 12);
    apply(4'b0000, 4'b0000, 12);
    apply(4'b0100, 4'b0000, 12);
    apply(4'b1000, 4'b0000, 12);
    apply(4'b1100, 4'b0000, 12);
    apply(4'b0000, 4'b0001, 12);
    glitch(8'b0010_0000, 3);
    apply(4'b0000, 4'b0000, 12);

    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 3) == 0)
        glitch(VEC_W'($urandom_range(1, (1 << VEC_W) - 1)), $urandom_range(1, 3));
      apply(4'($urandom_range(0, 15)), NUM_OP'($urandom_range(0, 15)), $urandom_range(10, 30));
    end
    apply(4'b0000, 4'b0000, 12);

    // Mode 1: single R+A frame, then release.
    set_mode(1'b1);
    apply(4'b0010, 4'b0001, 80);
    check("ra_frame_literal", last_rx, exp_ra);
    apply(4'b0000, 4'b0000, 80);

    // X, then Y while busy, then release Y while still busy.
    apply(4'b0000, 4'b0100, 12);
    apply(4'b0000, 4'b1100, 12);
    apply(4'b0000, 4'b0100, 130);
    check("coalesce_last_op", last_rx[PAY_W:COORD_W+1], 4'b0100);

    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 3) == 0)
        glitch(VEC_W'($urandom_range(1, (1 << VEC_W) - 1)), $urandom_range(1, 3));
      apply(4'($urandom_range(0, 15)), NUM_OP'($urandom_range(0, 15)), $urandom_range(10, 80));
    end
    wait_cycles(2 * FRAME_CYC + 10);

    // Mode switch mid-frame drops the pending request.
    apply(m_dir, ~m_op, 15);
    apply(m_dir, ~m_op, 15);
    set_mode(1'b0);
    wait_cycles(2 * FRAME_CYC);

    // Reset in the middle of a frame.
    set_mode(1'b1);
    apply(m_dir, ~m_op, 30);
    #2;
    reset  = 1'b0;
    dir_in = '0;
    op_in  = '0;
    m_dir  = '0;
    m_op   = '0;
    pend   = 1'b0;
    frame_end = -1000;
    frm_q.delete();
    par_q.delete();
    #1;
    check("midrst_ser_out", ser_out, 1);
    check("midrst_ser_busy", ser_busy, 0);
    check("midrst_coord", coord_p, 0);
    check("midrst_op", op_p, 0);
    check("midrst_par_valid", par_valid, 0);
    check("midrst_conflict", conflict, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    wait_cycles(3 * FRAME_CYC);
    check_state();

    check("par_q_drained", par_q.size(), 0);
    check("frm_q_drained", frm_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
